// File: rtl/mvm_seq_pkg.sv
// Shared types for the mvm load sequencer: accepted mode words, FSM states,
// and the segment-length helper used to size fill and burst phases.
package mvm_seq_pkg;

  typedef enum logic [2:0] {
    MODE_MV = 3'd1,
    MODE_VM = 3'd2,
    MODE_M  = 3'd3,
    MODE_V  = 3'd4
  } mode_t;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    LOAD,
    BURST,
    START,
    WAIT_DONE,
    DRAIN
  } state_t;

  function automatic int unsigned seg_len(input logic is_matrix, input int unsigned k);
    return is_matrix ? k * k : k;
  endfunction

endpackage

// File: rtl/mvm_seq_buffer.sv
// Segment buffer for the load sequencer: K*K x B register file with synchronous
// write and combinational read; write/read pointers wrap to 0 after each segment.
module mvm_seq_buffer #(
  parameter int K  = 8,
  parameter int B  = 12,
  parameter int PW = $clog2(K * K)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [PW-1:0] last_idx_i,
  input  logic          wr_clr_i,
  input  logic          wr_en_i,
  input  logic [B-1:0]  wr_data_i,
  input  logic          rd_clr_i,
  input  logic          rd_en_i,
  output logic [B-1:0]  rd_data_o,
  output logic          wr_last_o,
  output logic          rd_last_o
);

  localparam int DEPTH = K * K;

  logic signed [B-1:0] mem_q [DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;

  assign wr_last_o = (wr_ptr_q == last_idx_i);
  assign rd_last_o = (rd_ptr_q == last_idx_i);
  assign rd_data_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (wr_clr_i) begin
      wr_ptr_d = '0;
    end else if (wr_en_i) begin
      wr_ptr_d = wr_last_o ? '0 : wr_ptr_q + 1'b1;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    if (rd_clr_i) begin
      rd_ptr_d = '0;
    end else if (rd_en_i) begin
      rd_ptr_d = rd_last_o ? '0 : rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is data only: never reset, so contents survive a sequencer reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/mvm_load_sequencer.sv
// Feeds the serial mvm: buffers mode-selected matrix/vector segments from a stalling
// producer and replays them as gap-free bursts. MVM_SEQ_ERRCNT_EN adds err_count.
module mvm_load_sequencer
  import mvm_seq_pkg::*;
#(
  parameter int K     = 8,
  parameter int B     = 12,
  parameter int DRAIN = K + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [B-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         loadMatrix,
  output logic         loadVector,
  output logic         start,
  input  logic         done,
  output logic [B-1:0] data_out,
  output logic         busy,
  output logic         err_mode
`ifdef MVM_SEQ_ERRCNT_EN
  ,
  output logic [7:0]   err_count
`endif
);

  localparam int PW = $clog2(K * K);
  localparam int DW = $clog2(DRAIN + 1);

  state_t        state_q, state_d;
  logic          seg_mat_q, seg_mat_d;
  logic          pend_q, pend_d;
  logic          err_q, err_d;
  logic [DW-1:0] drain_q, drain_d;

  logic          xfer;
  logic          mode_ok;
  logic [2:0]    mode_lo;
  logic [PW-1:0] last_idx;
  logic          wr_last, rd_last;
  logic          seg_full;
  logic [B-1:0]  rd_data;

  // in_ready is held low while reset is asserted and rises once it is released.
  assign in_ready = ~reset & ((state_q == IDLE) | (state_q == FILL));
  assign xfer     = in_valid & in_ready;
  assign mode_lo  = in_data[2:0];
  assign mode_ok  = (in_data[B-1:3] == '0) &&
                    (mode_lo inside {MODE_MV, MODE_VM, MODE_M, MODE_V});
  assign last_idx = PW'(seg_len(seg_mat_q, K) - 1);
  assign seg_full = xfer & wr_last;

  mvm_seq_buffer #(
    .K (K),
    .B (B)
  ) u_buf (
    .clk_i      (clk),
    .rst_i      (reset),
    .last_idx_i (last_idx),
    .wr_clr_i   (state_q == IDLE),
    .wr_en_i    (xfer & (state_q == FILL)),
    .wr_data_i  (in_data),
    .rd_clr_i   (state_q == LOAD),
    .rd_en_i    (state_q == BURST),
    .rd_data_o  (rd_data),
    .wr_last_o  (wr_last),
    .rd_last_o  (rd_last)
  );

  always_comb begin
    state_d   = state_q;
    seg_mat_d = seg_mat_q;
    pend_d    = pend_q;
    drain_d   = drain_q;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (mode_ok) begin
            state_d   = FILL;
            seg_mat_d = (mode_lo == MODE_MV) || (mode_lo == MODE_M);
            pend_d    = (mode_lo == MODE_MV) || (mode_lo == MODE_VM);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      FILL: begin
        if (seg_full) begin
          state_d = LOAD;
        end
      end
      LOAD: state_d = BURST;
      BURST: begin
        if (rd_last) begin
          if (pend_q) begin
            state_d   = FILL;
            pend_d    = 1'b0;
            seg_mat_d = ~seg_mat_q;
          end else begin
            state_d = START;
          end
        end
      end
      START: state_d = WAIT_DONE;
      // done is a level check here, so a done that rose during START is still seen.
      WAIT_DONE: begin
        if (done) begin
          state_d = mvm_seq_pkg::DRAIN;
          drain_d = '0;
        end
      end
      mvm_seq_pkg::DRAIN: begin
        if (drain_q == DW'(DRAIN - 1)) begin
          state_d = IDLE;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      seg_mat_q <= 1'b0;
      pend_q    <= 1'b0;
      err_q     <= 1'b0;
      drain_q   <= '0;
    end else begin
      state_q   <= state_d;
      seg_mat_q <= seg_mat_d;
      pend_q    <= pend_d;
      err_q     <= err_d;
      drain_q   <= drain_d;
    end
  end

  assign loadMatrix = (state_q == LOAD) & seg_mat_q;
  assign loadVector = (state_q == LOAD) & ~seg_mat_q;
  assign start      = (state_q == START);
  assign data_out   = (state_q == BURST) ? rd_data : '0;
  assign busy       = (state_q != IDLE);
  assign err_mode   = err_q;

`ifdef MVM_SEQ_ERRCNT_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [7:0] err_cnt_q, err_cnt_d;

  assign err_cnt_d = err_d ? sat_inc8(err_cnt_q) : err_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: doc/mvm_load_sequencer.md
Name: mvm_load_sequencer

Overview:
Upstream feeder for the serial matrix-vector multiplier (mvm, K=8, B=12).
- Accepts a valid/ready word stream: one mode word, then the payload words.
- Buffers each payload segment and then replays it to the mvm as an unbroken burst: loadMatrix/loadVector pulse, then consecutive data words.
- Pulses start, waits for done, then holds off while the mvm streams its K results.
- Converts a stall-prone producer into the gap-free timing the mvm requires.

Parameters:
K, 8, matrix dimension; matrix segment = K*K words, vector segment = K words
B, 12, data word width (signed)
DRAIN, K+1, cycles held after done before accepting the next mode word

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  asynchronous, active-high; clears all state
in_data  input  B  mode word or payload word
in_valid  input  1  in_data valid
in_ready  output  1  sequencer accepts in_data this cycle
loadMatrix  output  1  one-cycle pulse to mvm, matrix burst follows
loadVector  output  1  one-cycle pulse to mvm, vector burst follows
start  output  1  one-cycle pulse to mvm after all segments are loaded
done  input  1  from mvm; results begin streaming
data_out  output  B  to mvm data_in
busy  output  1  state != IDLE
err_mode  output  1  one-cycle pulse when a mode word is rejected

Behaviour:
- Reset (asynchronous, active-high):
  - State returns to IDLE.
  - Counters are cleared.
  - All outputs are 0, except in_ready = 1 after reset deasserts.
  - Buffer contents are not cleared.
- Mode word (only in IDLE):
  - Valid values: 1 = matrix then vector; 2 = vector then matrix; 3 = matrix only; 4 = vector only.
  - Any other value (including nonzero upper bits) is consumed, err_mode pulses the next cycle, and state stays IDLE.
- A transfer occurs when in_valid & in_ready.
- in_ready = 1 only in IDLE and FILL.
- States:
  - IDLE: waits for a mode word.
  - FILL: writes the current segment into the buffer at wr_ptr 0..N-1; N = K*K (matrix) or K (vector). A stalled in_valid simply waits; there is no timeout.
  - LOAD: one cycle; loadMatrix or loadVector = 1 according to the segment; data_out = 0.
  - BURST: N consecutive cycles; data_out = buf[rd_ptr], rd_ptr 0..N-1. After the last word, data_out returns to 0.
  - After BURST: if a second segment is pending (modes 1 and 2), go to FILL; otherwise go to START.
  - START: one cycle; start = 1.
  - WAIT_DONE: waits for done == 1. done sampled in any other state is ignored.
  - DRAIN: DRAIN cycles, then IDLE.
- Latency with continuous input:
  - Mode word accepted at cycle T; segment ends at T+N.
  - LOAD at T+N+1.
  - BURST at T+N+2 .. T+2N+1.
  - Next state (FILL or START) at T+2N+2.
- Mode 3 with no stalls: load pulse at T+65, start at T+130.
- Data values are passed through unmodified; there is no arithmetic. Width is B, signed.
- Boundaries:
  - In FILL, the last word sets a full flag; in_ready drops in the same cycle the state leaves FILL.
  - wr_ptr and rd_ptr reset to 0 at each segment.
  - done asserted during START is not missed: WAIT_DONE checks the level.
  - Reset mid-BURST immediately deasserts all mvm controls.

Optional Feature:
Macro MVM_SEQ_ERRCNT_EN.
- Defined: adds output port err_count [7:0], a saturating count of rejected mode words (holds at 255). It resets to 0.
- Undefined: the port and the counter are absent; err_mode is unchanged.

Decomposition:
- Package mvm_seq_pkg holds:
  - mode_t enum: MODE_MV = 1, MODE_VM = 2, MODE_M = 3, MODE_V = 4
  - state_t enum: IDLE, FILL, LOAD, BURST, START, WAIT_DONE, DRAIN
  - function seg_len(is_matrix, K)
- One sub-module, mvm_seq_buffer:
  - K*K x B register file, synchronous write, combinational read.
  - Owns wr_ptr and rd_ptr.
  - Pointer clear inputs.
- The FSM stays in the top module.

Test Plan:
- Mode 3, 64 matrix words 0x001..0x040 with in_valid held high -> loadMatrix pulse at T+65; data_out = 0x001..0x040 on cycles T+66..T+129; start at T+130.
- Mode 1, in_valid toggling every other cycle -> the burst is still 64 gap-free words, then 8 gap-free vector words; start occurs after the vector burst; in_ready = 0 during every BURST.
- Mode 2 -> loadVector precedes loadMatrix; after done, busy stays 1 for 9 cycles, then in_ready = 1.
- Mode word 0x005, then 0x000 -> err_mode pulses twice; busy is never asserted; with MVM_SEQ_ERRCNT_EN, err_count = 2.
- Reset asserted at burst word 30 -> loadMatrix, start and data_out are 0 immediately; next mode 4 runs normally with an 8-word burst.
- done pulsed during FILL -> ignored; the sequencer still waits for done after start.
